// File: rtl/ro_window_compare.sv
// ro_window_compare
//   Measurement controller and comparator for one ring-oscillator pair of the
//   parallel PUF. It clears both edge counters, enables them for a fixed
//   window, waits for the count synchronizers to settle, then compares the two
//   final counts and presents one response with a valid/ready handshake.
//
// Parameters
//   WINDOW  cycles cnt_enable is held high (1 .. 2**WIN_W-1)
//   WIN_W   width of the shared window/settle counter
//   SETTLE  idle cycles between window end and sampling (0 allowed)
//
// Ports
//   clk         system clock, all state on posedge
//   reset       asynchronous, active-high; returns the block to IDLE
//   start       measurement request, sampled only in IDLE
//   count_a     final count of oscillator A counter
//   count_b     final count of oscillator B counter
//   cnt_reset   counter reset (loads counter start value)
//   cnt_enable  counter enable
//   busy        high whenever not IDLE
//   resp_valid  response valid, held until accepted
//   resp_ready  consumer ready
//   resp_bit    count_a > count_b
//   resp_tie    count_a == count_b
//   resp_diff   |count_a - count_b|
//   resp_sat    either count at 8'hFF when sampled (possible wrap)
module ro_window_compare #(
    parameter int WINDOW = 200,
    parameter int WIN_W  = 16,
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] count_a,
    input  logic [7:0] count_b,
    output logic       cnt_reset,
    output logic       cnt_enable,
    output logic       busy,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       resp_bit,
    output logic       resp_tie,
    output logic [7:0] resp_diff,
    output logic       resp_sat
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_COUNT  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WINDOW - 1);
    localparam logic [WIN_W-1:0] SET_LAST   = (SETTLE > 0) ? WIN_W'(SETTLE - 1) : {WIN_W{1'b0}};
    localparam logic             HAS_SETTLE = (SETTLE > 0) ? 1'b1 : 1'b0;
    localparam logic [WIN_W-1:0] WIN_ONE    = WIN_W'(1);

    // Unsigned magnitude of the difference; the larger operand is always the
    // minuend so the 8-bit result cannot wrap.
    function automatic logic [7:0] abs_diff8(input logic [7:0] a, input logic [7:0] b);
        if (a >= b) begin
            return a - b;
        end else begin
            return b - a;
        end
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [WIN_W-1:0] win_cnt_r;
    logic [WIN_W-1:0] win_cnt_next_s;

    logic       cnt_reset_r;
    logic       cnt_enable_r;
    logic       busy_r;
    logic       resp_valid_r;
    logic       resp_bit_r;
    logic       resp_tie_r;
    logic [7:0] resp_diff_r;
    logic       resp_sat_r;

    // State and window/settle counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            win_cnt_r <= {WIN_W{1'b0}};
        end else begin
            state_r   <= state_next_s;
            win_cnt_r <= win_cnt_next_s;
        end
    end

    // Next-state and counter logic. One counter serves both the window and
    // the settle phase; it is zeroed on every phase exit.
    always_comb begin
        state_next_s   = state_r;
        win_cnt_next_s = win_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_CLEAR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_next_s   = ST_COUNT;
                win_cnt_next_s = {WIN_W{1'b0}};
            end
            ST_COUNT: begin
                if (win_cnt_r == WIN_LAST) begin
                    win_cnt_next_s = {WIN_W{1'b0}};
                    state_next_s   = HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;
                end else begin
                    win_cnt_next_s = win_cnt_r + WIN_ONE;
                end
            end
            ST_SETTLE: begin
                if (win_cnt_r == SET_LAST) begin
                    win_cnt_next_s = {WIN_W{1'b0}};
                    state_next_s   = ST_SAMPLE;
                end else begin
                    win_cnt_next_s = win_cnt_r + WIN_ONE;
                end
            end
            ST_SAMPLE: begin
                state_next_s = ST_DONE;
            end
            ST_DONE: begin
                if (resp_valid_r && resp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s   = ST_IDLE;
                win_cnt_next_s = {WIN_W{1'b0}};
            end
        endcase
    end

    // Control outputs registered from the next state so they carry the same
    // cycle timing as a Moore decode of state_r while staying glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reset_r  <= 1'b0;
            cnt_enable_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            cnt_reset_r  <= (state_next_s == ST_CLEAR);
            cnt_enable_r <= (state_next_s == ST_COUNT);
            busy_r       <= (state_next_s != ST_IDLE);
        end
    end

    // Response capture on the closing edge of SAMPLE, release on accept.
    // Fields hold their last value after accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_r <= 1'b0;
            resp_bit_r   <= 1'b0;
            resp_tie_r   <= 1'b0;
            resp_diff_r  <= 8'd0;
            resp_sat_r   <= 1'b0;
        end else if (state_r == ST_SAMPLE) begin
            resp_valid_r <= 1'b1;
            resp_bit_r   <= (count_a > count_b);
            resp_tie_r   <= (count_a == count_b);
            resp_diff_r  <= abs_diff8(count_a, count_b);
            resp_sat_r   <= (count_a == 8'hFF) || (count_b == 8'hFF);
        end else if (resp_valid_r && resp_ready) begin
            resp_valid_r <= 1'b0;
        end else begin
            resp_valid_r <= resp_valid_r;
        end
    end

    assign cnt_reset  = cnt_reset_r;
    assign cnt_enable = cnt_enable_r;
    assign busy       = busy_r;
    assign resp_valid = resp_valid_r;
    assign resp_bit   = resp_bit_r;
    assign resp_tie   = resp_tie_r;
    assign resp_diff  = resp_diff_r;
    assign resp_sat   = resp_sat_r;

endmodule

// File: tb/tb_ro_window_compare.sv
// Directed-vector bench for ro_window_compare: one instance with WINDOW=4,
// SETTLE=2 and one with WINDOW=1, SETTLE=0.
module tb_ro_window_compare;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, start6;
    logic       resp_ready, resp_ready6;
    logic [7:0] count_a, count_b;

    logic       cnt_reset, cnt_enable, busy, resp_valid, resp_bit, resp_tie, resp_sat;
    logic [7:0] resp_diff;
    logic       cnt_reset6, cnt_enable6, busy6, resp_valid6, resp_bit6, resp_tie6, resp_sat6;
    logic [7:0] resp_diff6;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ro_window_compare #(.WINDOW(4), .WIN_W(16), .SETTLE(2)) dut (
        .clk(clk), .reset(reset), .start(start),
        .count_a(count_a), .count_b(count_b),
        .cnt_reset(cnt_reset), .cnt_enable(cnt_enable), .busy(busy),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_bit(resp_bit), .resp_tie(resp_tie),
        .resp_diff(resp_diff), .resp_sat(resp_sat)
    );

    ro_window_compare #(.WINDOW(1), .WIN_W(16), .SETTLE(0)) dut6 (
        .clk(clk), .reset(reset), .start(start6),
        .count_a(count_a), .count_b(count_b),
        .cnt_reset(cnt_reset6), .cnt_enable(cnt_enable6), .busy(busy6),
        .resp_valid(resp_valid6), .resp_ready(resp_ready6),
        .resp_bit(resp_bit6), .resp_tie(resp_tie6),
        .resp_diff(resp_diff6), .resp_sat(resp_sat6)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start so it is sampled at the next edge (edge 0), then walks to
    // edge 8 checking the control timeline and the exact resp_valid rise.
    task automatic measure(input logic [7:0] a, input logic [7:0] b, input string tag);
        count_a = a;
        count_b = b;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) tick();
            check({tag, "_cnt_reset"},  {31'd0, cnt_reset},  {31'd0, (k == 0)});
            check({tag, "_cnt_enable"}, {31'd0, cnt_enable}, {31'd0, (k >= 1 && k <= 4)});
            check({tag, "_resp_valid"}, {31'd0, resp_valid}, {31'd0, (k == 8)});
        end
    endtask

    task automatic check_resp(input string tag, input logic b, input logic t,
                              input logic [7:0] d, input logic s);
        check({tag, "_bit"},  {31'd0, resp_bit}, {31'd0, b});
        check({tag, "_tie"},  {31'd0, resp_tie}, {31'd0, t});
        check({tag, "_diff"}, {24'd0, resp_diff}, {24'd0, d});
        check({tag, "_sat"},  {31'd0, resp_sat}, {31'd0, s});
    endtask

    task automatic accept(input string tag);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, "_acc_valid"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_acc_busy"},  {31'd0, busy},       32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        start6      = 1'b0;
        resp_ready  = 1'b0;
        resp_ready6 = 1'b0;
        count_a     = 8'd0;
        count_b     = 8'd0;
        tick();
        tick();
        check("rst_cnt_reset",  {31'd0, cnt_reset},  32'd0);
        check("rst_cnt_enable", {31'd0, cnt_enable}, 32'd0);
        check("rst_busy",       {31'd0, busy},       32'd0);
        check("rst_valid",      {31'd0, resp_valid}, 32'd0);
        check_resp("rst", 1'b0, 1'b0, 8'd0, 1'b0);
        reset = 1'b0;
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Timeline plus a > b
        measure(8'd120, 8'd117, "m1");
        check("m1_busy", {31'd0, busy}, 32'd1);
        check_resp("m1", 1'b1, 1'b0, 8'd3, 1'b0);
        accept("m1");
        // Fields persist after accept
        check("m1_hold_diff", {24'd0, resp_diff}, 32'd3);

        // Back-to-back: start the cycle right after accept is taken
        measure(8'd5, 8'd9, "m2");
        check_resp("m2", 1'b0, 1'b0, 8'd4, 1'b0);
        accept("m2");

        measure(8'd64, 8'd64, "m3");
        check_resp("m3", 1'b0, 1'b1, 8'd0, 1'b0);
        accept("m3");

        measure(8'hFF, 8'h10, "m4");
        check_resp("m4", 1'b1, 1'b0, 8'hEF, 1'b1);

        // Stall in DONE with start pulses that must be ignored
        start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("stall_valid", {31'd0, resp_valid}, 32'd1);
            check("stall_diff",  {24'd0, resp_diff},  32'hEF);
            check("stall_sat",   {31'd0, resp_sat},   32'd1);
        end
        start = 1'b0;
        accept("m4");
        tick();
        check("noqueue_busy",      {31'd0, busy},      32'd0);
        check("noqueue_cnt_reset", {31'd0, cnt_reset}, 32'd0);

        measure(8'd0, 8'hFF, "m5");
        check_resp("m5", 1'b0, 1'b0, 8'hFF, 1'b1);
        accept("m5");

        // Reset in the middle of COUNT
        count_a = 8'd200;
        count_b = 8'd100;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tick();
        tick();
        check("mid_enable", {31'd0, cnt_enable}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_enable", {31'd0, cnt_enable}, 32'd0);
        check("async_busy",   {31'd0, busy},       32'd0);
        check("async_diff",   {24'd0, resp_diff},  32'd0);
        check("async_sat",    {31'd0, resp_sat},   32'd0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("post_rst_valid", {31'd0, resp_valid}, 32'd0);
            check("post_rst_busy",  {31'd0, busy},       32'd0);
        end
        measure(8'd200, 8'd100, "m6");
        check_resp("m6", 1'b1, 1'b0, 8'd100, 1'b0);
        accept("m6");

        // WINDOW=1, SETTLE=0 instance
        count_a = 8'd33;
        count_b = 8'd33;
        start6  = 1'b1;
        tick();
        start6  = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) tick();
            check("w1_cnt_reset",  {31'd0, cnt_reset6},  {31'd0, (k == 0)});
            check("w1_cnt_enable", {31'd0, cnt_enable6}, {31'd0, (k == 1)});
            check("w1_resp_valid", {31'd0, resp_valid6}, {31'd0, (k == 3)});
        end
        check("w1_tie",  {31'd0, resp_tie6}, 32'd1);
        check("w1_bit",  {31'd0, resp_bit6}, 32'd0);
        check("w1_diff", {24'd0, resp_diff6}, 32'd0);
        resp_ready6 = 1'b1;
        tick();
        resp_ready6 = 1'b0;
        check("w1_acc_valid", {31'd0, resp_valid6}, 32'd0);
        check("w1_acc_busy",  {31'd0, busy6},       32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
